// File: rtl/b_mdu.sv
// b_mdu: iterative shift-and-add unsigned multiplier with HI/LO registers for multu/mfhi/mflo.
// Define B_MDU_EARLY_TERM_EN to finish as soon as no multiplier bits remain.
module b_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             i_b_mdu_clk,
  input  logic             i_b_mdu_rst,
  input  logic             i_b_mdu_start,
  input  logic             i_b_mdu_flush,
  input  logic [WIDTH-1:0] i_b_mdu_rs,
  input  logic [WIDTH-1:0] i_b_mdu_rt,
  output logic             o_b_mdu_busy,
  output logic             o_b_mdu_done,
  output logic [WIDTH-1:0] o_b_mdu_hi,
  output logic [WIDTH-1:0] o_b_mdu_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] acc_sum;
  logic               last_iter;

  // The partial product for this iteration also feeds HI/LO directly on the finishing edge.
  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef B_MDU_EARLY_TERM_EN
  assign last_iter = (cnt_q == CW'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_b_mdu_start && !i_b_mdu_flush) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, i_b_mdu_rs};
          mplier_d = i_b_mdu_rt;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A squash abandons the multiply without touching the accumulator or HI/LO.
        if (i_b_mdu_flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (last_iter) begin
            hi_d    = acc_sum[2*WIDTH-1:WIDTH];
            lo_d    = acc_sum[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_b_mdu_clk) begin
    if (i_b_mdu_rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign o_b_mdu_busy = (state_q == ST_BUSY);
  assign o_b_mdu_done = done_q;
  assign o_b_mdu_hi   = hi_q;
  assign o_b_mdu_lo   = lo_q;

  // The hazard unit is expected to hold multu back while a multiply is running.
  a_no_start_while_busy : assert property (
    @(posedge i_b_mdu_clk) disable iff (i_b_mdu_rst)
      !((state_q == ST_BUSY) && i_b_mdu_start && !i_b_mdu_flush)
  );

endmodule

// File: doc/b_mdu.md
# b_mdu

Iterative unsigned multiply unit for the EX stage, executing `multu` and holding the HI/LO architectural registers read by `mfhi`/`mflo`. It sits beside the ALU and consumes the `multu` decode that ALU control leaves unassigned. The unit raises busy so the hazard unit can stall dependent `mfhi`/`mflo`. A flush input lets the unit drop an in-flight multiply on a squash.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.
- `i_b_mdu_clk`  input  1: clock; every register updates on its rising edge.
- `i_b_mdu_rst`  input  1: reset, synchronous and active-high.
- `i_b_mdu_start`  input  1: the EX-stage instruction is `multu` and is valid.
- `i_b_mdu_flush`  input  1: squash. It aborts an in-flight multiply and blocks a same-cycle start.
- `i_b_mdu_rs`  input  WIDTH: multiplicand, rs value after forwarding.
- `i_b_mdu_rt`  input  WIDTH: multiplier, rt value after forwarding.
- `o_b_mdu_busy`  output  1: a multiply is in progress. Consumers stall `mfhi`/`mflo`/`multu`.
- `o_b_mdu_done`  output  1: one-cycle pulse in the cycle after HI/LO are written.
- `o_b_mdu_hi`  output  WIDTH: HI register, product bits [2·WIDTH-1:WIDTH].
- `o_b_mdu_lo`  output  WIDTH: LO register, product bits [WIDTH-1:0].

## Operation
- **FSM:** two states, IDLE and BUSY.
- **Internal registers:**
  - `acc`: 2·WIDTH bits.
  - `mcand`: 2·WIDTH bits, zero-extended rs.
  - `mplier`: WIDTH bits.
  - `cnt`: clog2(WIDTH) bits.
  - `hi`, `lo`, `done`.
- **IDLE, start=1 and flush=0:**
  - `acc`=0, `mcand`={0, rs}, `mplier`=rt, `cnt`=0.
  - Go to BUSY.
- **IDLE, start=0 or flush=1:** hold state.
- **BUSY, per cycle:**
  - If `mplier[0]` is set, `acc` ← `acc` + `mcand`, modulo 2^(2·WIDTH). A carry out of 2·WIDTH cannot occur.
  - Then `mcand` ← `mcand` << 1, `mplier` ← `mplier` >> 1, `cnt` ← `cnt` + 1.
- **BUSY, finishing iteration (`cnt`==WIDTH-1):**
  - {hi, lo} ← the updated `acc`.
  - Go to IDLE and set `done`=1 for the next cycle.
- **BUSY, flush=1:** go to IDLE. No accumulate occurs and hi/lo are unchanged. `done` stays 0.
- **BUSY, start=1 and flush=0:** start is ignored. The pipeline must not issue a start while busy; this is checked by assertion in simulation.
- **Arithmetic:** purely unsigned. Signed `mult` is not supported.
- **Outputs:**
  - `o_b_mdu_busy` = (state==BUSY), combinational from state.
  - `o_b_mdu_hi`/`o_b_mdu_lo` come directly from registers.
- **Reset:** state=IDLE, hi=0, lo=0, done=0, busy=0, acc/mcand/mplier/cnt=0. Reset overrides start and flush, and it also aborts an in-flight multiply.

## Timing
- **Start edge E0:** start is sampled. `busy` goes high in the cycle after E0.
- **Iterations:** they occur on edges E1..E(WIDTH).
- **HI/LO write:** HI/LO are updated on E(WIDTH) and visible after it.
- **`busy`:** high for exactly WIDTH cycles, from after E0 through E(WIDTH).
- **`done`:** high for one cycle, E(WIDTH) to E(WIDTH+1).
- **Back-to-back multiply:** a new start is accepted on the first edge where state=IDLE, i.e. E(WIDTH+1) at the earliest.
- **`mfhi`/`mflo`:** one issued in the cycle where `busy` falls reads the new HI/LO; there is no bypass.
- **Flush on edge Ef while BUSY:** `busy` is low after Ef and hi/lo keep their prior value.

## Configuration
- **Macro:** `B_MDU_EARLY_TERM_EN`.
- **Defined:**
  - A BUSY iteration also finishes when `mplier`>>1 == 0, i.e. no set bits remain. HI/LO are written and `done` pulses exactly as for the normal finish.
  - Latency becomes max(1, index of the highest set bit of rt + 1) cycles. rt=0 finishes on E1 with {hi, lo}=0.
  - Products are identical to the fixed-latency build.
- **Undefined:** latency is fixed at WIDTH cycles for all operands.

## Test plan
- **Reset then idle:** assert rst for 2 cycles → hi=0, lo=0, busy=0, done=0; no change with start=0 for 10 cycles.
- **Basic multiply:** start with rs=0x0000_0003, rt=0x0000_0005 → busy for 32 cycles; after E32 lo=0x0000_000F, hi=0, done pulses once. With `B_MDU_EARLY_TERM_EN` defined: busy for 3 cycles, same result.
- **Max operands:** rs=rt=0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001 after 32 cycles in both builds.
- **Flush mid-operation:** start with rs=7, rt=9 after a prior result hi=0, lo=0xF; flush on cycle 10 → busy low next cycle, hi/lo stay 0/0xF, no done; a following start with rs=2, rt=3 gives lo=6.
- **Simultaneous start+flush in IDLE, start-while-busy:**
  - start+flush in IDLE → no state change.
  - A second start during busy → ignored and the assertion fires; the first result is correct.
- **Reset mid-operation:** rst asserted at cycle 5 of a multiply → busy=0 and hi=lo=0 after that edge; done never pulses.
